// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared savestate addresses, source indices and interrupt vectors
package interrupt_controller_pkg;

  typedef enum logic [7:0] {
    SS_CPU        = 8'h00,
    SS_PROG_TIMER = 8'h08,
    SS_INTERRUPT  = 8'h0C
  } ss_addresses;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLANK = 1'b1
  } irq_state_t;

  // Source index doubles as the req_q bit and the mask register address;
  // a higher index wins arbitration.
  localparam int NUM_SRC       = 6;
  localparam int SRC_CLOCK     = 0;
  localparam int SRC_STOPWATCH = 1;
  localparam int SRC_K0        = 2;
  localparam int SRC_K1        = 3;
  localparam int SRC_SERIAL    = 4;
  localparam int SRC_PROG      = 5;

  localparam logic [3:0] VEC_NONE      = 4'h0;
  localparam logic [3:0] VEC_CLOCK     = 4'h2;
  localparam logic [3:0] VEC_STOPWATCH = 4'h4;
  localparam logic [3:0] VEC_K0        = 4'h6;
  localparam logic [3:0] VEC_K1        = 4'h8;
  localparam logic [3:0] VEC_SERIAL    = 4'hA;
  localparam logic [3:0] VEC_PROG      = 4'hC;

  function automatic logic [3:0] src_vector(input int src);
    case (src)
      SRC_CLOCK:     return VEC_CLOCK;
      SRC_STOPWATCH: return VEC_STOPWATCH;
      SRC_K0:        return VEC_K0;
      SRC_K1:        return VEC_K1;
      SRC_SERIAL:    return VEC_SERIAL;
      SRC_PROG:      return VEC_PROG;
      default:       return VEC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_connector.sv
// rtl/bus_connector.sv - savestate bus endpoint holding the restore word for one block
module bus_connector #(
  parameter logic [7:0]  ADDRESS       = 8'h00,
  parameter logic [31:0] DEFAULT_VALUE = 32'h0
) (
  input  logic        clk,
  input  logic [31:0] bus_in,
  input  logic [7:0]  bus_addr,
  input  logic        bus_wren,
  input  logic        bus_reset_n,
  output logic [31:0] bus_out,
  input  logic [31:0] current_data,
  output logic [31:0] new_data
);

  logic [31:0] stored;

  always_ff @(posedge clk or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      stored <= DEFAULT_VALUE;
    end else if (bus_wren && (bus_addr == ADDRESS)) begin
      stored <= bus_in;
    end
  end

  assign new_data = stored;
  assign bus_out  = (bus_addr == ADDRESS) ? current_data : 32'h0;

endmodule

// File: rtl/priority_encoder6.sv
// rtl/priority_encoder6.sv - six request bits to the vector of the highest-priority one
module priority_encoder6
  import interrupt_controller_pkg::*;
(
  input  logic [5:0] req,
  output logic [3:0] vector
);

  always_comb begin
    vector = VEC_NONE;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) vector = src_vector(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - masked, fixed-priority interrupt request/ack/vector unit
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [7:0] SS_ADDR     = SS_INTERRUPT,
  parameter int         BLANK_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        prog_factor,
  input  logic        serial_factor,
  input  logic        k1_factor,
  input  logic        k0_factor,
  input  logic [1:0]  stopwatch_factor,
  input  logic [3:0]  clock_factor,
  input  logic        cpu_i_flag,
  input  logic        irq_ack,
  input  logic [2:0]  io_addr,
  input  logic [3:0]  io_wdata,
  input  logic        io_wren,
  output logic [3:0]  io_rdata,
  output logic        irq_req,
  output logic [3:0]  irq_vector,
  output logic        wake,
  input  logic [31:0] ss_bus_in,
  input  logic [7:0]  ss_bus_addr,
  input  logic        ss_bus_wren,
  input  logic        ss_bus_reset_n,
  output logic [31:0] ss_bus_out
);

  localparam logic [1:0] BLANK_LAST = 2'(BLANK_TICKS - 1);

  logic [3:0]  mask_clock;
  logic [1:0]  mask_stopwatch;
  logic        mask_k0, mask_k1, mask_serial, mask_prog;
  logic [5:0]  req_q, req_d;
  irq_state_t  state, state_d;
  logic [1:0]  blank_cnt, blank_cnt_d;
  logic [3:0]  vector_q, vector_d, enc_vector;
  logic        wake_q;
  logic        restore_q;
  logic [31:0] ss_current_data, ss_new_data;
  logic        unused_ss;

  assign req_d[SRC_PROG]      = prog_factor & mask_prog;
  assign req_d[SRC_SERIAL]    = serial_factor & mask_serial;
  assign req_d[SRC_K1]        = k1_factor & mask_k1;
  assign req_d[SRC_K0]        = k0_factor & mask_k0;
  assign req_d[SRC_STOPWATCH] = |(stopwatch_factor & mask_stopwatch);
  assign req_d[SRC_CLOCK]     = |(clock_factor & mask_clock);

  priority_encoder6 u_encoder (
    .req    (req_q),
    .vector (enc_vector)
  );

  always_comb begin
    state_d     = state;
    blank_cnt_d = blank_cnt;
    vector_d    = vector_q;
    irq_req     = 1'b0;
    case (state)
      ST_IDLE: begin
        irq_req = (|req_q) & cpu_i_flag;
        // Vector comes from req_q, so it matches the request the CPU just saw.
        if (clk_en && irq_ack && irq_req) begin
          state_d     = ST_BLANK;
          blank_cnt_d = 2'd0;
          vector_d    = enc_vector;
        end
      end
      ST_BLANK: begin
        if (clk_en) begin
          if (blank_cnt == BLANK_LAST) begin
            state_d     = ST_IDLE;
            blank_cnt_d = 2'd0;
          end else begin
            blank_cnt_d = blank_cnt + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // restore_q is set throughout reset so the first edge after release reloads the savestate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      restore_q      <= 1'b1;
      state          <= ST_IDLE;
      blank_cnt      <= 2'd0;
      vector_q       <= 4'h0;
      req_q          <= 6'h0;
      wake_q         <= 1'b0;
      mask_clock     <= 4'h0;
      mask_stopwatch <= 2'h0;
      mask_k0        <= 1'b0;
      mask_k1        <= 1'b0;
      mask_serial    <= 1'b0;
      mask_prog      <= 1'b0;
    end else if (restore_q) begin
      restore_q      <= 1'b0;
      mask_clock     <= ss_new_data[3:0];
      mask_stopwatch <= ss_new_data[5:4];
      mask_k0        <= ss_new_data[6];
      mask_k1        <= ss_new_data[7];
      mask_serial    <= ss_new_data[8];
      mask_prog      <= ss_new_data[9];
      vector_q       <= ss_new_data[13:10];
      state          <= irq_state_t'(ss_new_data[14]);
      blank_cnt      <= ss_new_data[16:15];
      req_q          <= ss_new_data[22:17];
      wake_q         <= |ss_new_data[22:17];
    end else if (clk_en) begin
      state     <= state_d;
      blank_cnt <= blank_cnt_d;
      vector_q  <= vector_d;
      req_q     <= req_d;
      wake_q    <= |req_d;
      if (io_wren) begin
        case (io_addr)
          3'd0:    mask_clock     <= io_wdata;
          3'd1:    mask_stopwatch <= io_wdata[1:0];
          3'd2:    mask_k0        <= io_wdata[0];
          3'd3:    mask_k1        <= io_wdata[0];
          3'd4:    mask_serial    <= io_wdata[0];
          3'd5:    mask_prog      <= io_wdata[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    io_rdata = 4'h0;
    case (io_addr)
      3'd0:    io_rdata = mask_clock;
      3'd1:    io_rdata = {2'b00, mask_stopwatch};
      3'd2:    io_rdata = {3'b000, mask_k0};
      3'd3:    io_rdata = {3'b000, mask_k1};
      3'd4:    io_rdata = {3'b000, mask_serial};
      3'd5:    io_rdata = {3'b000, mask_prog};
      default: io_rdata = 4'h0;
    endcase
  end

  assign irq_vector = vector_q;
  assign wake       = wake_q;

  assign ss_current_data = {9'h0, req_q, blank_cnt, 1'(state), vector_q,
                            mask_prog, mask_serial, mask_k1, mask_k0,
                            mask_stopwatch, mask_clock};
  assign unused_ss = ^ss_new_data[31:23];

  bus_connector #(
    .ADDRESS       (SS_ADDR),
    .DEFAULT_VALUE (32'h0)
  ) u_ss (
    .clk          (clk),
    .bus_in       (ss_bus_in),
    .bus_addr     (ss_bus_addr),
    .bus_wren     (ss_bus_wren),
    .bus_reset_n  (ss_bus_reset_n),
    .bus_out      (ss_bus_out),
    .current_data (ss_current_data),
    .new_data     (ss_new_data)
  );

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - model-checked directed and random bench for interrupt_controller
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  localparam int BT = 2;
  localparam logic [7:0] SSA = SS_INTERRUPT;

  logic        clk = 1'b0, reset_n = 1'b0, clk_en = 1'b0;
  logic        prog_factor = 1'b0, serial_factor = 1'b0, k1_factor = 1'b0, k0_factor = 1'b0;
  logic [1:0]  stopwatch_factor = 2'h0;
  logic [3:0]  clock_factor = 4'h0;
  logic        cpu_i_flag = 1'b0, irq_ack = 1'b0;
  logic [2:0]  io_addr = 3'h0;
  logic [3:0]  io_wdata = 4'h0;
  logic        io_wren = 1'b0;
  logic [3:0]  io_rdata;
  logic        irq_req;
  logic [3:0]  irq_vector;
  logic        wake;
  logic [31:0] ss_bus_in = 32'h0;
  logic [7:0]  ss_bus_addr = SSA;
  logic        ss_bus_wren = 1'b0, ss_bus_reset_n = 1'b0;
  logic [31:0] ss_bus_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  interrupt_controller #(.SS_ADDR(SSA), .BLANK_TICKS(BT)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .clk_en           (clk_en),
    .prog_factor      (prog_factor),
    .serial_factor    (serial_factor),
    .k1_factor        (k1_factor),
    .k0_factor        (k0_factor),
    .stopwatch_factor (stopwatch_factor),
    .clock_factor     (clock_factor),
    .cpu_i_flag       (cpu_i_flag),
    .irq_ack          (irq_ack),
    .io_addr          (io_addr),
    .io_wdata         (io_wdata),
    .io_wren          (io_wren),
    .io_rdata         (io_rdata),
    .irq_req          (irq_req),
    .irq_vector       (irq_vector),
    .wake             (wake),
    .ss_bus_in        (ss_bus_in),
    .ss_bus_addr      (ss_bus_addr),
    .ss_bus_wren      (ss_bus_wren),
    .ss_bus_reset_n   (ss_bus_reset_n),
    .ss_bus_out       (ss_bus_out)
  );

  // Reference model: source index = mask address = req bit (0 clock .. 5 prog).
  int          m_mask [6];
  bit          m_req  [6];
  bit          n_req  [6];
  int          m_vec;
  int          m_blank;
  bit          m_restore;
  bit          m_acc;
  logic [31:0] m_ss;

  function automatic int wmask(input int a);
    return (a == 0) ? 15 : (a == 1) ? 3 : 1;
  endfunction

  function automatic int moff(input int a);
    return (a == 0) ? 0 : (a == 1) ? 4 : a + 4;
  endfunction

  function automatic int vec_of(input int b);
    return 2 * b + 2;
  endfunction

  function automatic int factor(input int b);
    case (b)
      0:       return int'(clock_factor);
      1:       return int'(stopwatch_factor);
      2:       return int'(k0_factor);
      3:       return int'(k1_factor);
      4:       return int'(serial_factor);
      default: return int'(prog_factor);
    endcase
  endfunction

  function automatic bit any_req();
    for (int b = 0; b < 6; b++) if (m_req[b]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_irq();
    return (m_blank == 0) && any_req() && (cpu_i_flag == 1'b1);
  endfunction

  function automatic int top_vec();
    for (int b = 5; b >= 0; b--) if (m_req[b]) return vec_of(b);
    return 0;
  endfunction

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    w = 32'h0;
    for (int a = 0; a < 6; a++) w = w | (32'(m_mask[a]) << moff(a));
    w[13:10] = 4'(m_vec);
    if (m_blank > 0) begin
      w[14]    = 1'b1;
      w[16:15] = 2'(BT - m_blank);
    end
    for (int b = 0; b < 6; b++) w[17 + b] = m_req[b];
    return w;
  endfunction

  always @(posedge clk or negedge ss_bus_reset_n) begin
    if (!ss_bus_reset_n) m_ss <= 32'h0;
    else if (ss_bus_wren && ss_bus_addr == SSA) m_ss <= ss_bus_in;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < 6; a++) begin
        m_mask[a] = 0;
        m_req[a]  = 1'b0;
      end
      m_vec     = 0;
      m_blank   = 0;
      m_restore = 1'b1;
    end else if (m_restore) begin
      m_restore = 1'b0;
      for (int a = 0; a < 6; a++) begin
        m_mask[a] = int'((m_ss >> moff(a))) & wmask(a);
        m_req[a]  = m_ss[17 + a];
      end
      m_vec   = int'(m_ss[13:10]);
      m_blank = m_ss[14] ? BT - int'(m_ss[16:15]) : 0;
    end else if (clk_en) begin
      m_acc = irq_ack && exp_irq();
      if (m_blank > 0) m_blank = m_blank - 1;
      if (m_acc) begin
        m_vec   = top_vec();
        m_blank = BT;
      end
      for (int b = 0; b < 6; b++) n_req[b] = (factor(b) & m_mask[b]) != 0;
      if (io_wren && io_addr < 3'd6) m_mask[io_addr] = int'(io_wdata) & wmask(int'(io_addr));
      for (int b = 0; b < 6; b++) m_req[b] = n_req[b];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("irq_req", 32'(irq_req), 32'(exp_irq()));
      check("irq_vector", 32'(irq_vector), 32'(m_vec));
      check("wake", 32'(wake), 32'(any_req()));
      check("io_rdata", 32'(io_rdata), (io_addr < 3'd6) ? 32'(m_mask[io_addr]) : 32'h0);
      if (ss_bus_addr == SSA) check("ss_bus_out", ss_bus_out, exp_word());
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    io_addr  = a;
    io_wdata = d;
    io_wren  = 1'b1;
    tick();
    io_wren  = 1'b0;
  endtask

  initial begin
    clk_en = 1'b1;
    repeat (2) tick();
    check("rst_irq_req", 32'(irq_req), 32'h0);
    check("rst_vector", 32'(irq_vector), 32'h0);
    check("rst_wake", 32'(wake), 32'h0);
    check("rst_rdata", 32'(io_rdata), 32'h0);
    ss_bus_reset_n = 1'b1;
    reset_n        = 1'b1;
    cmp_en         = 1'b1;
    tick();

    // Masked-on K0 with interrupts disabled: wake only, ack ignored.
    wr(3'd2, 4'h1);
    cpu_i_flag = 1'b0;
    k0_factor  = 1'b1;
    tick(); tick();
    check("k0_no_irq", 32'(irq_req), 32'h0);
    check("k0_wake", 32'(wake), 32'h1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("ack_ignored_vec", 32'(irq_vector), 32'h0);
    k0_factor = 1'b0;
    wr(3'd2, 4'h0);
    tick();

    // Programmable timer request, ack and two blank ticks.
    cpu_i_flag = 1'b1;
    wr(3'd5, 4'h1);
    prog_factor = 1'b1;
    tick();
    check("prog_irq", 32'(irq_req), 32'h1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("prog_vec", 32'(irq_vector), 32'hC);
    check("blank1", 32'(irq_req), 32'h0);
    tick();
    check("blank2", 32'(irq_req), 32'h0);
    tick();
    check("blank_end", 32'(irq_req), 32'h1);
    prog_factor = 1'b0;
    tick();

    // Clock factor on a masked-off bit, then mask it on.
    wr(3'd0, 4'h1);
    clock_factor = 4'b0010;
    tick(); tick();
    check("clk_masked_irq", 32'(irq_req), 32'h0);
    check("clk_masked_wake", 32'(wake), 32'h0);
    wr(3'd0, 4'h2);
    check("clk_old_mask", 32'(irq_req), 32'h0);
    tick();
    check("clk_irq", 32'(irq_req), 32'h1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("clk_vec", 32'(irq_vector), 32'h2);
    clock_factor = 4'h0;
    wr(3'd0, 4'h0);
    tick();

    // Stopwatch and prog together: prog wins, stopwatch follows after blank.
    wr(3'd1, 4'h3);
    stopwatch_factor = 2'b01;
    prog_factor      = 1'b1;
    tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("both_vec", 32'(irq_vector), 32'hC);
    prog_factor = 1'b0;
    tick(); tick();
    check("sw_reassert", 32'(irq_req), 32'h1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("sw_vec", 32'(irq_vector), 32'h4);
    stopwatch_factor = 2'b00;
    repeat (3) tick();

    // Reset in the middle of blank, then savestate restore.
    prog_factor = 1'b1;
    tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_irq", 32'(irq_req), 32'h0);
    check("async_vec", 32'(irq_vector), 32'h0);
    check("async_wake", 32'(wake), 32'h0);
    prog_factor = 1'b0;
    ss_bus_in   = 32'h0000_2BFF;
    ss_bus_wren = 1'b1;
    tick();
    ss_bus_wren = 1'b0;
    reset_n     = 1'b1;
    tick();
    io_addr = 3'd0;
    #1;
    check("restore_mask", 32'(io_rdata), 32'hF);
    check("restore_vec", 32'(irq_vector), 32'hA);
    io_addr = 3'd6;
    #1;
    check("unused_addr", 32'(io_rdata), 32'h0);
    tick();

    for (int c = 0; c < 4000; c++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) prog_factor = ~prog_factor;
      if ($urandom_range(0, 7) == 0) serial_factor = ~serial_factor;
      if ($urandom_range(0, 7) == 0) k1_factor = ~k1_factor;
      if ($urandom_range(0, 7) == 0) k0_factor = ~k0_factor;
      if ($urandom_range(0, 7) == 0) stopwatch_factor = 2'($urandom);
      if ($urandom_range(0, 7) == 0) clock_factor = 4'($urandom);
      cpu_i_flag  = ($urandom_range(0, 9) != 0);
      irq_ack     = ($urandom_range(0, 3) == 0);
      io_addr     = 3'($urandom);
      io_wdata    = 4'($urandom);
      io_wren     = ($urandom_range(0, 4) == 0);
      ss_bus_in   = $urandom & 32'h007E_3FFF;
      ss_bus_wren = ($urandom_range(0, 99) == 0);
      ss_bus_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : SSA;
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n     = 1'b1;
        ss_bus_wren = 1'b0;
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
